step_pulse_timer: RTL and testbench

- Motor step generator clocked by the selected core/io clock produced by the upstream clock-selection stage.
- Divides that clock with a programmable prescaler and period counter, then emits a fixed number of step pulses with a latched direction.
- Uses a start/stop control handshake and reports busy/done status to logic-analyzer or wishbone-side control.

---
 rtl/step_pulse_timer_if.sv | 31 +++
 rtl/step_pulse_timer.sv | 153 +++++++++++++++
 tb/tb_step_pulse_timer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/step_pulse_timer_if.sv
// Control/status bundle for step_pulse_timer: move request, timing setup and step/status outputs.
// The master drives the move request; the slave is the timer itself.
interface step_pulse_timer_if #(
  parameter int PRESCALE_W = 8,
  parameter int PERIOD_W   = 16,
  parameter int COUNT_W    = 16
);
  logic                  start;
  logic                  stop;
  logic                  dir_in;
  logic [PRESCALE_W-1:0] prescale;
  logic [PERIOD_W-1:0]   period;
  logic [COUNT_W-1:0]    step_count;
  logic                  irq_clear;
  logic                  step_out;
  logic                  dir_out;
  logic                  busy;
  logic                  done;
  logic [COUNT_W-1:0]    steps_remaining;
  logic                  irq;

  modport master (
    output start, stop, dir_in, prescale, period, step_count, irq_clear,
    input  step_out, dir_out, busy, done, steps_remaining, irq
  );

  modport slave (
    input  start, stop, dir_in, prescale, period, step_count, irq_clear,
    output step_out, dir_out, busy, done, steps_remaining, irq
  );
endinterface

// File: rtl/step_pulse_timer.sv
// Motor step generator: prescaler + period counter issue a fixed number of step pulses.
// Optional sticky completion interrupt enabled with `define STEP_PULSE_TIMER_IRQ_EN.
module step_pulse_timer #(
  parameter int PRESCALE_W   = 8,
  parameter int PERIOD_W     = 16,
  parameter int COUNT_W      = 16,
  parameter int PULSE_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  step_pulse_timer_if.slave  bus
);
  localparam int PCW = $clog2(PULSE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pc_q, pc_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [PERIOD_W-1:0]   qc_q, qc_d;
  logic [COUNT_W-1:0]    steps_q, steps_d;
  logic [PCW-1:0]        pulse_q, pulse_d;
  logic                  ev_q, ev_d;
  logic                  dir_q, dir_d;
  logic                  step_out_q, step_out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick;

  always_comb begin
    state_d    = state_q;
    prescale_d = prescale_q;
    pc_d       = pc_q;
    period_d   = period_q;
    qc_d       = qc_q;
    steps_d    = steps_q;
    dir_d      = dir_q;
    ev_d       = 1'b0;
    tick       = (pc_q == prescale_q);

    // A step event is registered first; the pulse timer restarts one edge later.
    if (ev_q)
      pulse_d = PCW'(PULSE_CYCLES);
    else if (pulse_q != '0)
      pulse_d = pulse_q - PCW'(1);
    else
      pulse_d = '0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          prescale_d = bus.prescale;
          period_d   = (bus.period == '0) ? PERIOD_W'(1) : bus.period;
          steps_d    = bus.step_count;
          dir_d      = bus.dir_in;
          pc_d       = '0;
          qc_d       = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        // Stop beats a coincident step event; an empty move drains straight away.
        if (bus.stop || steps_q == '0) begin
          state_d = DRAIN;
        end else begin
          pc_d = tick ? '0 : pc_q + PRESCALE_W'(1);
          if (tick) begin
            if (qc_q == period_q - PERIOD_W'(1)) begin
              qc_d    = '0;
              ev_d    = 1'b1;
              steps_d = steps_q - COUNT_W'(1);
              if (steps_q == COUNT_W'(1))
                state_d = DRAIN;
            end else begin
              qc_d = qc_q + PERIOD_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (!ev_q && pulse_d == '0)
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    step_out_d = (pulse_d != '0);
    busy_d     = (state_q == RUN || state_q == DRAIN) && (state_d != DONE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      prescale_q <= '0;
      pc_q       <= '0;
      period_q   <= '0;
      qc_q       <= '0;
      steps_q    <= '0;
      pulse_q    <= '0;
      ev_q       <= 1'b0;
      dir_q      <= 1'b0;
      step_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      pc_q       <= pc_d;
      period_q   <= period_d;
      qc_q       <= qc_d;
      steps_q    <= steps_d;
      pulse_q    <= pulse_d;
      ev_q       <= ev_d;
      dir_q      <= dir_d;
      step_out_q <= step_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.step_out        = step_out_q;
  assign bus.dir_out         = dir_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.steps_remaining = steps_q;

`ifdef STEP_PULSE_TIMER_IRQ_EN
  logic irq_q, irq_d;

  // Completion set takes priority over a coincident clear.
  always_comb begin
    irq_d = (state_d == DONE) || (irq_q && !bus.irq_clear);
  end

  always_ff @(posedge clock) begin
    if (reset)
      irq_q <= 1'b0;
    else
      irq_q <= irq_d;
  end

  assign bus.irq = irq_q;
`else
  logic irq_clear_unused;
  assign irq_clear_unused = bus.irq_clear;
  assign bus.irq          = 1'b0;
`endif
endmodule

// File: tb/tb_step_pulse_timer.sv
// Randomized and directed moves for step_pulse_timer, checked edge by edge against an
// arithmetic timeline of step events, pulses, drain and completion.
module tb_step_pulse_timer;
  localparam int PRESCALE_W   = 8;
  localparam int PERIOD_W     = 16;
  localparam int COUNT_W      = 16;
  localparam int PULSE_CYCLES = 4;
`ifdef STEP_PULSE_TIMER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  step_pulse_timer_if #(.PRESCALE_W(PRESCALE_W), .PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) bus();

  step_pulse_timer #(
    .PRESCALE_W(PRESCALE_W), .PERIOD_W(PERIOD_W),
    .COUNT_W(COUNT_W), .PULSE_CYCLES(PULSE_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic exp_irq = 1'b0;
  int last_rem = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".step_out"}, 32'(bus.step_out), 32'd0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".done"}, 32'(bus.done), 32'd0);
    chk({tag, ".irq"}, 32'(bus.irq), 32'(exp_irq));
  endtask

  // One complete move; s = edge index (after accept) at which stop is sampled, 0 = never.
  task automatic run_move(input int pre, input int per, input int n, input bit dir,
                          input int s, input bit force_clr);
    int peff, len, np, s_end, dn, rise, issued;
    bit e_step, clr;
    peff = (per == 0) ? 1 : per;
    len  = (pre + 1) * peff;
    if (n == 0) begin
      np = 0; s_end = 1;
    end else if (s != 0 && s <= len * n) begin
      np = (s - 1) / len; s_end = s;
    end else begin
      np = n; s_end = len * n;
    end
    if (np == 0) dn = s_end + 1;
    else dn = (s_end + 1 > len * np + 1 + PULSE_CYCLES) ? s_end + 1 : len * np + 1 + PULSE_CYCLES;

    bus.prescale = PRESCALE_W'(pre);
    bus.period = PERIOD_W'(per);
    bus.step_count = COUNT_W'(n);
    bus.dir_in = dir;
    bus.start = 1'b1;
    bus.stop = 1'b0;
    bus.irq_clear = 1'b0;
    @(posedge clock);
    @(negedge clock);
    // Scramble setup inputs after acceptance; the move must not notice.
    bus.start = 1'b0;
    bus.dir_in = 1'($urandom);
    bus.prescale = PRESCALE_W'($urandom);
    bus.period = PERIOD_W'($urandom);
    bus.step_count = COUNT_W'($urandom_range(1, 65535));
    clr = force_clr ? (dn == 1) : ($urandom % 6 == 0);
    bus.irq_clear = clr;
    bus.stop = (s == 1);

    for (int t = 1; t <= dn + 2; t++) begin
      @(posedge clock);
      @(negedge clock);
      if (IRQ_EN && t == dn) exp_irq = 1'b1;
      else if (clr) exp_irq = 1'b0;
      e_step = 1'b0;
      issued = 0;
      for (int i = 1; i <= np; i++) begin
        rise = len * i + 1;
        if (t >= rise && t < rise + PULSE_CYCLES) e_step = 1'b1;
        if (len * i <= t) issued++;
      end
      chk("step_out", 32'(bus.step_out), 32'(e_step));
      chk("busy", 32'(bus.busy), 32'(t < dn));
      chk("done", 32'(bus.done), 32'(t == dn));
      chk("steps_remaining", 32'(bus.steps_remaining), 32'(n - issued));
      chk("dir_out", 32'(bus.dir_out), 32'(dir));
      chk("irq", 32'(bus.irq), 32'(exp_irq));
      clr = force_clr ? (t + 1 == dn) : ($urandom % 6 == 0);
      bus.irq_clear = clr;
      bus.stop = (s == t + 1);
      bus.start = (t + 1 == dn + 1);
    end
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.irq_clear = 1'b0;
    last_rem = n - np;
    $display("move pre=%0d per=%0d n=%0d dir=%0d stop_edge=%0d issued=%0d done_edge=%0d",
             pre, per, n, dir, s, np, dn);
  endtask

  initial begin
    int pre, per, n, len, s;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.dir_in = 1'b0;
    bus.prescale = '0;
    bus.period = '0;
    bus.step_count = '0;
    bus.irq_clear = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_idle_outputs("reset");
    chk("reset.dir_out", 32'(bus.dir_out), 32'd0);
    chk("reset.steps_remaining", 32'(bus.steps_remaining), 32'd0);
    reset = 1'b0;
    $display("reset released");

    run_move(1, 3, 2, 1'b1, 0, 1'b0);
    run_move(2, 5, 0, 1'b0, 0, 1'b1);
    run_move(0, 0, 3, 1'b1, 0, 1'b0);
    run_move(0, 2, 10, 1'b0, 7, 1'b1);

    // start and stop together in IDLE must be ignored.
    bus.start = 1'b1;
    bus.stop = 1'b1;
    bus.step_count = COUNT_W'(9);
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
      chk_idle_outputs("start_stop");
      chk("start_stop.steps_remaining", 32'(bus.steps_remaining), 32'(last_rem));
    end
    bus.start = 1'b0;
    bus.stop = 1'b0;
    $display("start+stop in idle ignored check");

    for (int m = 0; m < 25; m++) begin
      pre = int'($urandom % 4);
      per = int'($urandom % 5);
      n = int'($urandom % 6);
      len = (pre + 1) * ((per == 0) ? 1 : per);
      s = ($urandom % 3 == 0) ? int'($urandom_range(1, len * n + 3)) : 0;
      run_move(pre, per, n, 1'($urandom), s, m[0]);
    end

    // Reset in the middle of a move: everything clears, no done pulse afterwards.
    run_move(0, 1, 1, 1'b1, 0, 1'b0);
    bus.prescale = '0;
    bus.period = PERIOD_W'(2);
    bus.step_count = COUNT_W'(5);
    bus.dir_in = 1'b1;
    bus.start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("midrun.steps_remaining", 32'(bus.steps_remaining), 32'd3);
    chk("midrun.busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_irq = 1'b0;
    chk_idle_outputs("midrun_reset");
    chk("midrun_reset.dir_out", 32'(bus.dir_out), 32'd0);
    chk("midrun_reset.steps_remaining", 32'(bus.steps_remaining), 32'd0);
    repeat (8) begin
      @(posedge clock);
      @(negedge clock);
      chk_idle_outputs("after_reset");
    end
    $display("reset mid-move check");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
